memory_access_unit: RTL

//  Memory-stage consumer of the EX/MEM pipeline register outputs. Converts the M-stage load/store
//  (ALUResultM, WriteDataM, MemWriteM, ...) into a valid/ready data-memory transaction.

---
 rtl/mem_pkg.sv | 38 +++
 rtl/load_align_ext.sv | 25 ++
 rtl/memory_access_unit.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the memory-stage access unit: access size codes, FSM states,
// alignment and byte-enable rules.
package mem_pkg;

    localparam logic [1:0] SizeByte = 2'b00;
    localparam logic [1:0] SizeHalf = 2'b01;
    localparam logic [1:0] SizeWord = 2'b10;

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StResp,
        StDone
    } mau_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SizeHalf: return addr_lo[0];
            SizeWord: return addr_lo != 2'b00;
            default:  return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SizeByte: return 4'b0001 << addr_lo;
            SizeHalf: return 4'b0011 << addr_lo;
            default:  return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_align_ext.sv
// Moves the addressed byte/half of a read word down to bit 0 and sign- or zero-extends it.
module load_align_ext
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] result_o
);

    logic [31:0] shifted;

    always_comb begin
        shifted = rdata_i >> {addr_lo_i, 3'b000};
        case (funct3_i)
            F3Lb:    result_o = {{24{shifted[7]}}, shifted[7:0]};
            F3Lh:    result_o = {{16{shifted[15]}}, shifted[15:0]};
            F3Lbu:   result_o = {24'h0, shifted[7:0]};
            F3Lhu:   result_o = {16'h0, shifted[15:0]};
            F3Lw:    result_o = shifted;
            default: result_o = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_unit.sv
// M-stage load/store unit: turns the EX/MEM instruction into one valid/ready memory transaction,
// stalling the pipeline until the response (or a timeout) and presenting the result for one cycle.
module memory_access_unit
    import mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic        dmem_req_we,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_wdata,
    output logic [3:0]  dmem_req_be,
    input  logic        dmem_rsp_valid,
    input  logic [31:0] dmem_rsp_rdata,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        MisalignedM,
    output logic        BusErrorM
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    mau_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            bus_err_q, bus_err_d;

    logic        access;
    logic        misaligned;
    logic        req_go;
    logic [31:0] load_result;

    assign access     = MemReadM | MemWriteM;
    assign misaligned = is_misaligned(Funct3M[1:0], ALUResultM[1:0]);
    assign req_go     = access & ~misaligned;

    load_align_ext u_load_align_ext (
        .rdata_i   (dmem_rsp_rdata),
        .addr_lo_i (ALUResultM[1:0]),
        .funct3_i  (Funct3M),
        .result_o  (load_result)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = '0;
        rdata_d        = rdata_q;
        bus_err_d      = bus_err_q;
        dmem_req_valid = 1'b0;
        case (state_q)
            StIdle: begin
                dmem_req_valid = req_go;
                if (req_go) begin
                    state_d = dmem_req_ready ? StResp : StReq;
                end
            end
            StReq: begin
                dmem_req_valid = 1'b1;
                if (dmem_req_ready) begin
                    state_d = StResp;
                end
            end
            StResp: begin
                cnt_d = cnt_q + 1'b1;
                if (dmem_rsp_valid) begin
                    // Write acks carry no data; keep ReadDataM at zero for stores
                    rdata_d = (MemReadM & ~MemWriteM) ? load_result : '0;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    bus_err_d = 1'b1;
                    rdata_d   = '0;
                    state_d   = StDone;
                end
            end
            StDone: begin
                bus_err_d = 1'b0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        case (Funct3M[1:0])
            SizeByte: dmem_req_wdata = {4{WriteDataM[7:0]}};
            SizeHalf: dmem_req_wdata = {2{WriteDataM[15:0]}};
            default:  dmem_req_wdata = WriteDataM;
        endcase
    end

    assign dmem_req_addr = {ALUResultM[31:2], 2'b00};
    assign dmem_req_we   = MemWriteM;
    assign dmem_req_be   = dmem_req_valid ? byte_enable(Funct3M[1:0], ALUResultM[1:0]) : 4'b0000;

    assign StallM      = req_go & (state_q != StDone);
    assign MisalignedM = access & misaligned;
    assign ReadDataM   = (state_q == StDone) ? rdata_q : 32'h0;
    assign BusErrorM   = bus_err_q;

endmodule
